// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel path: phase encodings and default bus widths.
package vga_pkg;

  localparam int XW_DEF = 8;
  localparam int YW_DEF = 8;
  localparam int CW_DEF = 12;

  typedef enum logic [1:0] {
    PH_IDLE  = 2'b00,
    PH_CLEAR = 2'b01,
    PH_DRAW  = 2'b10,
    PH_HOLD  = 2'b11
  } phase_e;

endpackage

// File: rtl/frame_scheduler_if.sv
// Pixel-engine and framebuffer-write bundle around the frame scheduler.
// The master side is the scheduler; the slave side is the engines plus framebuffer writer.
interface frame_scheduler_if
  import vga_pkg::*;
#(
  parameter int XW = XW_DEF,
  parameter int YW = YW_DEF,
  parameter int CW = CW_DEF
);

  logic          clr_start;
  logic          clr_valid;
  logic [XW-1:0] clr_x;
  logic [YW-1:0] clr_y;
  logic [CW-1:0] clr_color;
  logic          clr_done;
  logic          clr_ready;

  logic          sin_start;
  logic          sin_valid;
  logic [XW-1:0] sin_x;
  logic [YW-1:0] sin_y;
  logic [CW-1:0] sin_color;
  logic          sin_done;
  logic          sin_ready;

  logic          fb_we;
  logic [XW-1:0] fb_x;
  logic [YW-1:0] fb_y;
  logic [CW-1:0] fb_color;
  logic          fb_ready;

  modport master (
    output clr_start, clr_ready, sin_start, sin_ready,
    output fb_we, fb_x, fb_y, fb_color,
    input  clr_valid, clr_x, clr_y, clr_color, clr_done,
    input  sin_valid, sin_x, sin_y, sin_color, sin_done,
    input  fb_ready
  );

  modport slave (
    input  clr_start, clr_ready, sin_start, sin_ready,
    input  fb_we, fb_x, fb_y, fb_color,
    output clr_valid, clr_x, clr_y, clr_color, clr_done,
    output sin_valid, sin_x, sin_y, sin_color, sin_done,
    output fb_ready
  );

endinterface

// File: rtl/fb_out_stage.sv
// One-entry valid/ready register in front of the framebuffer write port.
// Accepts a pixel whenever it is empty or draining this cycle, so back-to-back pixels stream at one per cycle.
module fb_out_stage #(
  parameter int XW = 8,
  parameter int YW = 8,
  parameter int CW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [XW-1:0] in_x,
  input  logic [YW-1:0] in_y,
  input  logic [CW-1:0] in_color,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic [CW-1:0] out_color
);

  assign in_ready = !out_valid || out_ready;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      // NOTE: the payload is reset too, because fb_x/fb_y/fb_color must read 0 out of reset.
      out_x     <= '0;
      out_y     <= '0;
      out_color <= '0;
    end else begin
      if (in_ready) out_valid <= in_valid;
      if (in_valid && in_ready) begin
        out_x     <= in_x;
        out_y     <= in_y;
        out_color <= in_color;
      end
    end
  end

endmodule

// File: rtl/frame_scheduler.sv
// Frame sequencer: CLEAR -> DRAW -> HOLD, granting only the current phase's engine onto the
// framebuffer write port, with a per-phase watchdog and a wrapping completed-frame counter.
module frame_scheduler
  import vga_pkg::*;
#(
  parameter int XW          = XW_DEF,
  parameter int YW          = YW_DEF,
  parameter int CW          = CW_DEF,
  parameter int HOLD_CYCLES = 95000,
  parameter int TIMEOUT     = 65535
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  frame_scheduler_if.master        bus,
  output logic [1:0]               phase,
  output logic [7:0]               frame_cnt,
  output logic                     timeout_err
);

  localparam int WW = $clog2(TIMEOUT);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  phase_e        state_q, state_d;
  logic [WW-1:0] wd_q;
  logic [HW-1:0] hold_q;
  logic          wd_expire, frame_done, timeout_hit;
  logic          clr_own, sin_own;

  logic          stage_valid, stage_ready;
  logic [XW-1:0] stage_x;
  logic [YW-1:0] stage_y;
  logic [CW-1:0] stage_color;

  assign phase     = state_q;
  assign wd_expire = (wd_q == WW'(TIMEOUT - 1));
  assign clr_own   = (state_q == PH_CLEAR);
  assign sin_own   = (state_q == PH_DRAW);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    frame_done  = 1'b0;
    timeout_hit = 1'b0;
    unique case (state_q)
      PH_IDLE:  if (enable) state_d = PH_CLEAR;
      PH_CLEAR: begin
        if (bus.clr_done) state_d = PH_DRAW;
        else if (wd_expire) begin
          state_d     = PH_HOLD;
          timeout_hit = 1'b1;
        end
      end
      PH_DRAW: begin
        if (bus.sin_done) begin
          state_d    = PH_HOLD;
          frame_done = 1'b1;
        end else if (wd_expire) begin
          state_d     = PH_HOLD;
          timeout_hit = 1'b1;
        end
      end
      PH_HOLD:  if (hold_q == '0) state_d = enable ? PH_CLEAR : PH_IDLE;
      default:  state_d = PH_IDLE;
    endcase
  end

  // Only the owning engine reaches the output stage; the other one's valid never matters.
  assign stage_valid   = (clr_own && bus.clr_valid) || (sin_own && bus.sin_valid);
  assign stage_x       = sin_own ? bus.sin_x     : bus.clr_x;
  assign stage_y       = sin_own ? bus.sin_y     : bus.clr_y;
  assign stage_color   = sin_own ? bus.sin_color : bus.clr_color;
  assign bus.clr_ready = clr_own && stage_ready;
  assign bus.sin_ready = sin_own && stage_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= PH_IDLE;
      wd_q          <= '0;
      hold_q        <= '0;
      frame_cnt     <= '0;
      timeout_err   <= 1'b0;
      bus.clr_start <= 1'b0;
      bus.sin_start <= 1'b0;
    end else begin
      state_q       <= state_d;
      // Start pulses are registered so they line up with the first cycle of their phase.
      bus.clr_start <= (state_d == PH_CLEAR) && (state_q != PH_CLEAR);
      bus.sin_start <= (state_d == PH_DRAW) && (state_q != PH_DRAW);

      if (state_d != state_q) wd_q <= '0;
      else if (clr_own || sin_own) wd_q <= wd_q + 1'b1;

      if (state_d == PH_HOLD && state_q != PH_HOLD) hold_q <= HW'(HOLD_CYCLES - 1);
      else if (state_q == PH_HOLD && hold_q != '0) hold_q <= hold_q - 1'b1;

      if (frame_done) frame_cnt <= frame_cnt + 8'd1;
      if (timeout_hit) timeout_err <= 1'b1;
    end
  end

  fb_out_stage #(.XW(XW), .YW(YW), .CW(CW)) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (stage_valid),
    .in_ready  (stage_ready),
    .in_x      (stage_x),
    .in_y      (stage_y),
    .in_color  (stage_color),
    .out_valid (bus.fb_we),
    .out_ready (bus.fb_ready),
    .out_x     (bus.fb_x),
    .out_y     (bus.fb_y),
    .out_color (bus.fb_color)
  );

endmodule

// File: tb/tb_frame_scheduler.sv
// Self-checking bench for frame_scheduler with HOLD_CYCLES=4, TIMEOUT=20.
// Accepted pixels go into a scoreboard queue and are matched against framebuffer writes.
module tb_frame_scheduler;
  import vga_pkg::*;

  localparam int HOLD = 4;
  localparam int TMO  = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] phase;
  logic [7:0] frame_cnt;
  logic       timeout_err;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  logic [27:0] sb[$];

  frame_scheduler_if #(.XW(8), .YW(8), .CW(12)) bus ();

  frame_scheduler #(.XW(8), .YW(8), .CW(12), .HOLD_CYCLES(HOLD), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .bus         (bus),
    .phase       (phase),
    .frame_cnt   (frame_cnt),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Write monitor: pop/compare completed writes, then push newly accepted pixels.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      checks++;
      if (bus.clr_start === 1'b1 && bus.sin_start === 1'b1) begin
        errors++;
        $display("FAIL start_overlap: clr_start=%b sin_start=%b, required not both 1", bus.clr_start, bus.sin_start);
      end
      checks++;
      if (sb.size() > 0) begin
        if (bus.fb_we !== 1'b1 || {bus.fb_x, bus.fb_y, bus.fb_color} !== sb[0]) begin
          errors++;
          $display("FAIL fb_write: got we=%b x=%0d y=%0d c=%h, required we=1 x=%0d y=%0d c=%h",
                   bus.fb_we, bus.fb_x, bus.fb_y, bus.fb_color, sb[0][27:20], sb[0][19:12], sb[0][11:0]);
        end
        if (bus.fb_ready) begin
          void'(sb.pop_front());
          wr_cnt++;
        end
      end else if (bus.fb_we !== 1'b0) begin
        errors++;
        $display("FAIL fb_spurious: got fb_we=%b x=%0d y=%0d, required fb_we=0", bus.fb_we, bus.fb_x, bus.fb_y);
      end
      if (bus.clr_valid && bus.clr_ready) sb.push_back({bus.clr_x, bus.clr_y, bus.clr_color});
      if (bus.sin_valid && bus.sin_ready) sb.push_back({bus.sin_x, bus.sin_y, bus.sin_color});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pix(input bit s, input logic [7:0] x, input logic [7:0] y, input logic [11:0] c, input bit d);
    int n = 0;
    if (s) begin
      bus.sin_valid = 1'b1; bus.sin_x = x; bus.sin_y = y; bus.sin_color = c; bus.sin_done = d;
    end else begin
      bus.clr_valid = 1'b1; bus.clr_x = x; bus.clr_y = y; bus.clr_color = c; bus.clr_done = d;
    end
    @(negedge clk);
    while (((s ? bus.sin_ready : bus.clr_ready) !== 1'b1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL send_pix_accept: ready stayed 0 for %0d cycles, required 1", n);
    end
    step();
    if (s) begin bus.sin_valid = 1'b0; bus.sin_done = 1'b0; end
    else begin bus.clr_valid = 1'b0; bus.clr_done = 1'b0; end
  endtask

  task automatic pulse_done(input bit s);
    if (s) bus.sin_done = 1'b1; else bus.clr_done = 1'b1;
    step();
    if (s) bus.sin_done = 1'b0; else bus.clr_done = 1'b0;
  endtask

  task automatic wait_phase(input logic [1:0] p, input int budget);
    int n = 0;
    @(negedge clk);
    while (phase !== p && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (phase !== p) begin
      errors++;
      $display("FAIL wait_phase: phase=%b after %0d cycles, required %b", phase, n, p);
    end
  endtask

  task automatic count_cycles(input logic [1:0] p, output int n);
    n = 0;
    while (phase === p && n < 60) begin
      if (p == PH_HOLD) begin
        checks++;
        if ({bus.clr_ready, bus.sin_ready} !== 2'b00) begin
          errors++;
          $display("FAIL hold_ready: readies=%b, required 00", {bus.clr_ready, bus.sin_ready});
        end
      end
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({bus.fb_we, bus.fb_x, bus.fb_y, bus.fb_color, bus.clr_start, bus.sin_start,
         bus.clr_ready, bus.sin_ready, phase, frame_cnt, timeout_err} !== '0) begin
      errors++;
      $display("FAIL reset_state: fb_we=%b phase=%b frame_cnt=%0d terr=%b, required all 0", bus.fb_we, phase, frame_cnt, timeout_err);
    end
    @(negedge clk); #1;
    rst_n = 1'b1; enable = 1'b1;
    @(negedge clk);
    checks++;
    if (phase !== PH_CLEAR || bus.clr_start !== 1'b1) begin
      errors++;
      $display("FAIL first_clr_start: phase=%b clr_start=%b, required 01/1", phase, bus.clr_start);
    end
    @(negedge clk);
    checks++;
    if (bus.clr_start !== 1'b0) begin
      errors++;
      $display("FAIL clr_start_width: clr_start=%b in second CLEAR cycle, required 0", bus.clr_start);
    end
    step();
    bus.fb_ready = 1'b0;
    pulse_done(1'b0);
    send_pix(1'b1, 8'd7, 8'd9, 12'h0AA, 1'b0);
    checks++;
    if (phase !== PH_DRAW || bus.fb_we !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_draw: phase=%b fb_we=%b, required 10/1", phase, bus.fb_we);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.fb_we, bus.fb_x, bus.fb_y, bus.fb_color, bus.clr_start, bus.sin_start,
         bus.clr_ready, bus.sin_ready, phase, frame_cnt, timeout_err} !== '0) begin
      errors++;
      $display("FAIL async_reset: fb_we=%b fb_x=%0d phase=%b, required all 0", bus.fb_we, bus.fb_x, phase);
    end
    @(negedge clk); #1;
    rst_n = 1'b1; bus.fb_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (phase !== PH_CLEAR || bus.clr_start !== 1'b1) begin
      errors++;
      $display("FAIL restart_clr_start: phase=%b clr_start=%b, required 01/1", phase, bus.clr_start);
    end
  endtask

  task automatic test_full_frame();
    int w0, n;
    step();
    w0 = wr_cnt;
    send_pix(1'b0, 8'd1, 8'd1, 12'h111, 1'b0);
    send_pix(1'b0, 8'd2, 8'd1, 12'h222, 1'b0);
    send_pix(1'b0, 8'd3, 8'd1, 12'h333, 1'b1);
    @(negedge clk);
    checks++;
    if (phase !== PH_DRAW || bus.sin_start !== 1'b1) begin
      errors++;
      $display("FAIL first_sin_start: phase=%b sin_start=%b, required 10/1", phase, bus.sin_start);
    end
    step();
    send_pix(1'b1, 8'd4, 8'd5, 12'hABC, 1'b0);
    send_pix(1'b1, 8'd5, 8'd5, 12'hDEF, 1'b1);
    @(negedge clk);
    checks++;
    if (phase !== PH_HOLD || frame_cnt !== 8'd1) begin
      errors++;
      $display("FAIL frame_end: phase=%b frame_cnt=%0d, required 11/1", phase, frame_cnt);
    end
    count_cycles(PH_HOLD, n);
    checks++;
    if (n !== HOLD) begin
      errors++;
      $display("FAIL hold_len: %0d HOLD cycles, required %0d", n, HOLD);
    end
    checks++;
    if (phase !== PH_CLEAR || bus.clr_start !== 1'b1) begin
      errors++;
      $display("FAIL hold_restart: phase=%b clr_start=%b, required 01/1", phase, bus.clr_start);
    end
    checks++;
    if (wr_cnt - w0 !== 5) begin
      errors++;
      $display("FAIL write_count: %0d writes, required 5", wr_cnt - w0);
    end
  endtask

  task automatic test_stall();
    step();
    send_pix(1'b0, 8'd10, 8'd20, 12'hF00, 1'b0);
    bus.fb_ready = 1'b0;
    bus.clr_valid = 1'b1; bus.clr_x = 8'd11; bus.clr_y = 8'd21; bus.clr_color = 12'h0F0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.fb_we !== 1'b1 || bus.fb_x !== 8'd10 || bus.fb_y !== 8'd20 ||
          bus.fb_color !== 12'hF00 || bus.clr_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: we=%b x=%0d y=%0d c=%h clr_ready=%b, required 1/10/20/f00/0",
                 bus.fb_we, bus.fb_x, bus.fb_y, bus.fb_color, bus.clr_ready);
      end
    end
    step();
    bus.fb_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.clr_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: clr_ready=%b with fb_ready=1, required 1", bus.clr_ready);
    end
    step();
    bus.clr_valid = 1'b0;
  endtask

  task automatic test_wrong_phase();
    bus.sin_valid = 1'b1; bus.sin_x = 8'd1; bus.sin_y = 8'd2; bus.sin_color = 12'h003; bus.sin_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.sin_ready !== 1'b0 || phase !== PH_CLEAR) begin
        errors++;
        $display("FAIL sin_in_clear: sin_ready=%b phase=%b, required 0/01", bus.sin_ready, phase);
      end
    end
    step();
    bus.sin_valid = 1'b0; bus.sin_done = 1'b0;
    pulse_done(1'b0);
    bus.clr_valid = 1'b1; bus.clr_x = 8'd4; bus.clr_y = 8'd4; bus.clr_color = 12'h444; bus.clr_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.clr_ready !== 1'b0 || phase !== PH_DRAW) begin
        errors++;
        $display("FAIL clr_in_draw: clr_ready=%b phase=%b, required 0/10", bus.clr_ready, phase);
      end
    end
    step();
    bus.clr_valid = 1'b0; bus.clr_done = 1'b0;
    pulse_done(1'b1);
    @(negedge clk);
    checks++;
    if (phase !== PH_HOLD || frame_cnt !== 8'd2) begin
      errors++;
      $display("FAIL frame2_end: phase=%b frame_cnt=%0d, required 11/2", phase, frame_cnt);
    end
  endtask

  task automatic test_timeout();
    int n;
    wait_phase(PH_CLEAR, 10);
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL terr_early: timeout_err=%b, required 0", timeout_err);
    end
    count_cycles(PH_CLEAR, n);
    checks++;
    if (n !== TMO || phase !== PH_HOLD || timeout_err !== 1'b1 || frame_cnt !== 8'd2) begin
      errors++;
      $display("FAIL timeout: clear_cycles=%0d phase=%b terr=%b frame_cnt=%0d, required %0d/11/1/2",
               n, phase, timeout_err, frame_cnt, TMO);
    end
    wait_phase(PH_CLEAR, 10);
    step();
    pulse_done(1'b0);
    wait_phase(PH_DRAW, 3);
    step();
    pulse_done(1'b1);
    @(negedge clk);
    checks++;
    if (frame_cnt !== 8'd3 || timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL terr_sticky: frame_cnt=%0d terr=%b, required 3/1", frame_cnt, timeout_err);
    end
    step();
    rst_n = 1'b0; enable = 1'b0;
    #1;
    checks++;
    if (timeout_err !== 1'b0 || frame_cnt !== 8'd0 || phase !== PH_IDLE) begin
      errors++;
      $display("FAIL terr_reset: terr=%b frame_cnt=%0d phase=%b, required 0/0/00", timeout_err, frame_cnt, phase);
    end
    @(negedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_enable_drop_wrap();
    int n = 0;
    step();
    enable = 1'b1; bus.clr_done = 1'b1; bus.sin_done = 1'b1;
    @(negedge clk);
    while (frame_cnt !== 8'd255 && n < 2500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (frame_cnt !== 8'd255) begin
      errors++;
      $display("FAIL run_255: frame_cnt=%0d after %0d cycles, required 255", frame_cnt, n);
    end
    step();
    bus.clr_done = 1'b0; bus.sin_done = 1'b0;
    wait_phase(PH_CLEAR, 10);
    step();
    pulse_done(1'b0);
    wait_phase(PH_DRAW, 3);
    step();
    enable = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (phase !== PH_DRAW) begin
        errors++;
        $display("FAIL draw_after_disable: phase=%b, required 10", phase);
      end
    end
    step();
    pulse_done(1'b1);
    @(negedge clk);
    checks++;
    if (phase !== PH_HOLD || frame_cnt !== 8'd0) begin
      errors++;
      $display("FAIL frame_wrap: phase=%b frame_cnt=%0d, required 11/0", phase, frame_cnt);
    end
    count_cycles(PH_HOLD, n);
    checks++;
    if (n !== HOLD || phase !== PH_IDLE || bus.clr_start !== 1'b0) begin
      errors++;
      $display("FAIL hold_to_idle: hold=%0d phase=%b clr_start=%b, required %0d/00/0", n, phase, bus.clr_start, HOLD);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (phase !== PH_IDLE || bus.clr_start !== 1'b0 || {bus.clr_ready, bus.sin_ready} !== 2'b00) begin
        errors++;
        $display("FAIL idle_stay: phase=%b clr_start=%b readies=%b, required 00/0/00",
                 phase, bus.clr_start, {bus.clr_ready, bus.sin_ready});
      end
    end
  endtask

  initial begin
    bus.clr_valid = 1'b0; bus.clr_x = '0; bus.clr_y = '0; bus.clr_color = '0; bus.clr_done = 1'b0;
    bus.sin_valid = 1'b0; bus.sin_x = '0; bus.sin_y = '0; bus.sin_color = '0; bus.sin_done = 1'b0;
    bus.fb_ready = 1'b1;
    test_reset();
    test_full_frame();
    test_stall();
    test_wrong_phase();
    test_timeout();
    test_enable_drop_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded time limit, required completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
